interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Parametrised, nestable, prioritised interrupt controller between the board interrupt buttons/sources and the CPU core.
- Successor to the fixed 3-line interrupt input: any channel count, edge or level trigger, per-channel mask, in-service nesting, vector generation.
- CPU sees one request line plus an encoded ID/vector. It answers with an acknowledge pulse on entry and a return pulse on eret.

Parameters:
- CHANNELS, 3, number of interrupt sources (1..32).
- SYNC_STAGES, 2, synchroniser flops per input (>=1).
- EDGE_TRIGGER, 1, 1 = rising-edge latched pending; 0 = level-sensitive.
- MASK_RESET, all-ones, mask register value after reset (1 = enabled).
- VECTOR_BASE, 32'h0000_0100, vector of channel 0.
- VECTOR_STRIDE, 4, byte distance between vectors.
- ID_W, max(1,$clog2(CHANNELS)), width of irqId (derived, not overridable).

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetButton  in  1  asynchronous, active-low reset.
- interrupt  in  CHANNELS  raw asynchronous sources.
- globalEnable  in  1  CPU interrupt-enable flag.
- maskWrite  in  1  load mask register this cycle.
- maskData  in  CHANNELS  new mask value.
- irqAck  in  1  one-cycle pulse: CPU takes irqId.
- irqReturn  in  1  one-cycle pulse: CPU finished the current handler.
- irqRequest  out  1  registered request to CPU.
- irqId  out  ID_W  channel being requested.
- irqVector  out  32  VECTOR_BASE + irqId*VECTOR_STRIDE.
- pending  out  CHANNELS  pending register (debug/display).
- inService  out  CHANNELS  in-service register (debug/display).

Behaviour:
- Reset (async assert, sync release irrelevant here): synchronisers, edge history, pending, inService, irqRequest, irqId = 0; irqVector = VECTOR_BASE; mask = MASK_RESET.
- Priority: higher channel index = higher priority.
- Synchroniser: SYNC_STAGES flops per channel. Edge mode sets pending[i] on a 0->1 of the synchronised signal. The raw edge at cycle t sets pending at edge t+SYNC_STAGES+1.
- Level mode: pending[i] = synchronised level each cycle. Ack does not clear it. A source must drop before its handler returns, or it re-requests.
- Candidate: highest i with pending[i] & mask[i] & ~inService[i].
- Current level: highest set bit of inService, or "none".
- irqRequest/irqId update one cycle after pending: request = globalEnable & candidate exists & (inService==0 | candidate > current level). Net latency raw edge -> irqRequest = SYNC_STAGES+2 cycles.
- irqAck while irqRequest=1: clears pending[irqId] (edge mode only) and sets inService[irqId]. irqRequest drops on the next edge. irqAck while irqRequest=0: ignored.
- irqReturn clears the highest set inService bit. With inService==0 it is ignored.
- irqAck and irqReturn in the same cycle: the return is applied to the old inService first, then the ack.
- New edge on channel i in the same cycle as ack of channel i: set wins, pending[i] stays 1.
- Masking a pending channel leaves its pending bit intact. Unmasking later re-requests it.
- Mask write takes effect for the request computed in the following cycle.
- globalEnable=0 forces irqRequest=0 without losing pending state.
- Reset mid-handler: all inService and pending cleared immediately. No request until a new edge.

Decomposition:
- Shared package irq_pkg: default VECTOR_BASE/VECTOR_STRIDE constants, the priority-encoder function (highest set bit + valid), ID width helper function.
- One natural sub-module: irq_sync_edge (SYNC_STAGES synchroniser + rising-edge detector, one per channel via generate).

Test Plan:
- Single source: pulse interrupt=3'b010 for 5 cycles, mask=3'b111, globalEnable=1 -> irqRequest=1 with irqId=1 and irqVector=0x104, 4 cycles after the edge; ack -> pending=000, inService=010, request low.
- Priority: interrupt=3'b011 simultaneously -> irqId=1 first; after ack, no request (0 < 1); after return -> irqId=0, irqVector=0x100.
- Nesting: in service on ch0, pulse ch2 -> request irqId=2. Ack -> inService=101. Return -> inService=001. Return -> 000.
- Masking: mask=3'b011, pulse ch2 -> pending=100, no request. Write mask=3'b111 -> request irqId=2 two cycles later.
- Corner cases: ack ch1 with a new ch1 edge in the same cycle -> pending[1]=1, inService=010. Ack+return in the same cycle with inService=001 and request ch2 -> inService=100. irqAck with request low -> no state change.
- Reset: assert resetButton=0 while inService=100 and pending=001 -> all cleared, irqVector=0x100. Release, then no request until a fresh edge. Repeat with CHANNELS=8, EDGE_TRIGGER=0 -> held level ch7 re-requests after return.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and helpers for the interrupt controller
package irq_pkg;

   localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0100;
   localparam int VECTOR_STRIDE_DEF = 4;

   typedef struct packed {
      logic       valid;
      logic [4:0] id;
   } enc_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // highest set bit wins, valid flags a non-empty vector
   function automatic enc_t pri_enc(input logic [31:0] v);
      enc_t e;
      e = '0;
      for (int i = 0; i < 32; i++)
         if (v[i]) e = '{valid: 1'b1, id: 5'(i)};
      return e;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: input synchroniser with rising-edge detector for one channel
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
)(
   input  logic clock,
   input  logic resetButton,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sr;
   logic                   hist;

   // shift raw input through the synchroniser and remember last level
   always_ff @(posedge clock or negedge resetButton) begin
      if (!resetButton) begin
         sr   <= '0;
         hist <= 1'b0;
      end else begin
         sr   <= SYNC_STAGES'({sr, d});
         hist <= level;
      end
   end

   assign level = sr[SYNC_STAGES-1];
   assign rise  = level & ~hist;

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: prioritised, nestable interrupt controller with vector output
module interrupt_controller
   import irq_pkg::*;
#(
   parameter int              CHANNELS      = 3,
   parameter int              SYNC_STAGES   = 2,
   parameter bit              EDGE_TRIGGER  = 1'b1,
   parameter logic [CHANNELS-1:0] MASK_RESET = '1,
   parameter logic [31:0]     VECTOR_BASE   = VECTOR_BASE_DEF,
   parameter int              VECTOR_STRIDE = VECTOR_STRIDE_DEF,
   localparam int             ID_W          = id_width(CHANNELS)
)(
   input  logic                clock,
   input  logic                resetButton,
   input  logic [CHANNELS-1:0] interrupt,
   input  logic                globalEnable,
   input  logic                maskWrite,
   input  logic [CHANNELS-1:0] maskData,
   input  logic                irqAck,
   input  logic                irqReturn,
   output logic                irqRequest,
   output logic [ID_W-1:0]     irqId,
   output logic [31:0]         irqVector,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] inService
);

   logic [CHANNELS-1:0] level, rise, mask, ack_set, ret_clr;
   enc_t                cand, cur;
   logic                accept, req_next;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clock       (clock),
         .resetButton (resetButton),
         .d           (interrupt[i]),
         .level       (level[i]),
         .rise        (rise[i])
      );
   end

   // candidate/current level selection and next request; an accepted ack suppresses the stale request
   always_comb begin
      accept   = irqAck & irqRequest;
      cand     = pri_enc(32'(pending & mask & ~inService));
      cur      = pri_enc(32'(inService));
      ack_set  = accept ? CHANNELS'(1) << irqId : '0;
      ret_clr  = (irqReturn & cur.valid) ? CHANNELS'(1) << cur.id : '0;
      req_next = globalEnable & cand.valid & (~cur.valid | (cand.id > cur.id)) & ~accept;
   end

   // state registers: new edge beats ack clear, return applies to old inService before ack
   always_ff @(posedge clock or negedge resetButton) begin
      if (!resetButton) begin
         mask       <= MASK_RESET;
         pending    <= '0;
         inService  <= '0;
         irqRequest <= 1'b0;
         irqId      <= '0;
      end else begin
         mask       <= maskWrite ? maskData : mask;
         pending    <= EDGE_TRIGGER ? ((pending & ~ack_set) | rise) : level;
         inService  <= (inService & ~ret_clr) | ack_set;
         irqRequest <= req_next;
         irqId      <= accept ? irqId : cand.id[ID_W-1:0];
      end
   end

   assign irqVector = VECTOR_BASE + 32'(irqId) * 32'(VECTOR_STRIDE);

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

   logic       clock = 1'b0;
   logic       resetButton;
   logic [2:0] interrupt;
   logic       globalEnable, maskWrite, irqAck, irqReturn;
   logic [2:0] maskData;
   logic       irqRequest;
   logic [1:0] irqId;
   logic [31:0] irqVector;
   logic [2:0] pending, inService;

   logic [7:0] b_int;
   logic       b_ge, b_ack, b_ret, b_req;
   logic [2:0] b_id;
   logic [31:0] b_vec;
   logic [7:0] b_pend, b_isv;

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   interrupt_controller dut_a (
      .clock(clock), .resetButton(resetButton), .interrupt(interrupt),
      .globalEnable(globalEnable), .maskWrite(maskWrite), .maskData(maskData),
      .irqAck(irqAck), .irqReturn(irqReturn), .irqRequest(irqRequest),
      .irqId(irqId), .irqVector(irqVector), .pending(pending), .inService(inService)
   );

   interrupt_controller #(.CHANNELS(8), .EDGE_TRIGGER(1'b0)) dut_b (
      .clock(clock), .resetButton(resetButton), .interrupt(b_int),
      .globalEnable(b_ge), .maskWrite(1'b0), .maskData(8'h00),
      .irqAck(b_ack), .irqReturn(b_ret), .irqRequest(b_req),
      .irqId(b_id), .irqVector(b_vec), .pending(b_pend), .inService(b_isv)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [2:0] v);
      interrupt = v;
      tick();
      interrupt = '0;
   endtask

   task automatic ack();
      irqAck = 1'b1;
      tick();
      irqAck = 1'b0;
   endtask

   task automatic ret();
      irqReturn = 1'b1;
      tick();
      irqReturn = 1'b0;
   endtask

   initial begin
      resetButton = 1'b0; interrupt = '0; globalEnable = 1'b1; maskWrite = 1'b0;
      maskData = '0; irqAck = 1'b0; irqReturn = 1'b0;
      b_int = '0; b_ge = 1'b1; b_ack = 1'b0; b_ret = 1'b0;
      ticks(2);
      chk("rst_req", 32'(irqRequest), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_isv", 32'(inService), 32'd0);
      chk("rst_vec", irqVector, 32'h100);
      resetButton = 1'b1;
      ticks(2);
      // single source, latency
      interrupt = 3'b010;
      ticks(3);
      chk("single_pend", 32'(pending), 32'b010);
      chk("single_req_early", 32'(irqRequest), 32'd0);
      tick();
      chk("single_req", 32'(irqRequest), 32'd1);
      chk("single_id", 32'(irqId), 32'd1);
      chk("single_vec", irqVector, 32'h104);
      tick();
      interrupt = '0;
      ack();
      chk("single_ack_pend", 32'(pending), 32'b000);
      chk("single_ack_isv", 32'(inService), 32'b010);
      chk("single_ack_req", 32'(irqRequest), 32'd0);
      ret();
      chk("single_ret_isv", 32'(inService), 32'b000);
      ticks(4);
      // priority
      pulse(3'b011);
      ticks(3);
      chk("prio_id", 32'(irqId), 32'd1);
      chk("prio_req", 32'(irqRequest), 32'd1);
      ack();
      chk("prio_ack_pend", 32'(pending), 32'b001);
      chk("prio_ack_isv", 32'(inService), 32'b010);
      tick();
      chk("prio_lower_blocked", 32'(irqRequest), 32'd0);
      ret();
      tick();
      chk("prio_ret_req", 32'(irqRequest), 32'd1);
      chk("prio_ret_id", 32'(irqId), 32'd0);
      chk("prio_ret_vec", irqVector, 32'h100);
      // nesting
      ack();
      chk("nest_isv0", 32'(inService), 32'b001);
      pulse(3'b100);
      ticks(3);
      chk("nest_req", 32'(irqRequest), 32'd1);
      chk("nest_id", 32'(irqId), 32'd2);
      ack();
      chk("nest_isv2", 32'(inService), 32'b101);
      ret();
      chk("nest_ret1", 32'(inService), 32'b001);
      ret();
      chk("nest_ret2", 32'(inService), 32'b000);
      // masking
      maskWrite = 1'b1; maskData = 3'b011;
      tick();
      maskWrite = 1'b0;
      pulse(3'b100);
      ticks(3);
      chk("mask_pend", 32'(pending), 32'b100);
      chk("mask_noreq", 32'(irqRequest), 32'd0);
      maskWrite = 1'b1; maskData = 3'b111;
      tick();
      maskWrite = 1'b0;
      chk("unmask_req_early", 32'(irqRequest), 32'd0);
      tick();
      chk("unmask_req", 32'(irqRequest), 32'd1);
      chk("unmask_id", 32'(irqId), 32'd2);
      ack();
      ret();
      ticks(3);
      // ack with simultaneous new edge on the same channel
      pulse(3'b010);
      ticks(3);
      chk("c1_req", 32'(irqRequest), 32'd1);
      pulse(3'b010);
      tick();
      ack();
      chk("c1_pend", 32'(pending), 32'b010);
      chk("c1_isv", 32'(inService), 32'b010);
      tick();
      chk("c1_no_self_req", 32'(irqRequest), 32'd0);
      ret();
      tick();
      chk("c1_rereq", 32'(irqRequest), 32'd1);
      ack();
      ret();
      // ack + return in the same cycle
      pulse(3'b001);
      ticks(3);
      ack();
      pulse(3'b100);
      ticks(3);
      chk("c2_req", 32'(irqId), 32'd2);
      irqAck = 1'b1; irqReturn = 1'b1;
      tick();
      irqAck = 1'b0; irqReturn = 1'b0;
      chk("c2_isv", 32'(inService), 32'b100);
      chk("c2_pend", 32'(pending), 32'b000);
      tick();
      // ack while request is low
      pulse(3'b001);
      ticks(3);
      chk("c3_req_low", 32'(irqRequest), 32'd0);
      ack();
      chk("c3_pend", 32'(pending), 32'b001);
      chk("c3_isv", 32'(inService), 32'b100);
      // reset mid-handler, mask cleared beforehand to prove MASK_RESET reload
      maskWrite = 1'b1; maskData = 3'b000;
      tick();
      maskWrite = 1'b0;
      #2 resetButton = 1'b0;
      #1;
      chk("mid_rst_pend", 32'(pending), 32'd0);
      chk("mid_rst_isv", 32'(inService), 32'd0);
      chk("mid_rst_req", 32'(irqRequest), 32'd0);
      chk("mid_rst_vec", irqVector, 32'h100);
      #1 resetButton = 1'b1;
      ticks(5);
      chk("post_rst_noreq", 32'(irqRequest), 32'd0);
      pulse(3'b010);
      ticks(3);
      chk("post_rst_req", 32'(irqRequest), 32'd1);
      chk("post_rst_id", 32'(irqId), 32'd1);
      // level-mode instance, 8 channels
      b_int = 8'h80;
      ticks(4);
      chk("lvl_pend", 32'(b_pend), 32'h80);
      chk("lvl_req", 32'(b_req), 32'd1);
      chk("lvl_id", 32'(b_id), 32'd7);
      chk("lvl_vec", b_vec, 32'h11C);
      b_ack = 1'b1;
      tick();
      b_ack = 1'b0;
      chk("lvl_ack_pend", 32'(b_pend), 32'h80);
      chk("lvl_ack_isv", 32'(b_isv), 32'h80);
      tick();
      chk("lvl_inservice_noreq", 32'(b_req), 32'd0);
      b_ret = 1'b1;
      tick();
      b_ret = 1'b0;
      chk("lvl_ret_isv", 32'(b_isv), 32'h00);
      b_ge = 1'b0;
      tick();
      chk("lvl_ge_off", 32'(b_req), 32'd0);
      chk("lvl_ge_off_pend", 32'(b_pend), 32'h80);
      b_ge = 1'b1;
      tick();
      chk("lvl_rereq", 32'(b_req), 32'd1);
      chk("lvl_rereq_id", 32'(b_id), 32'd7);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
